// File: rtl/adc_packetizer.sv
// adc_packetizer: packs 12-bit ADC (or test counter) samples into 32-bit
// AXI4-Stream words framed as fixed-length packets, behind a small FWFT FIFO.
module adc_packetizer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        test_mode,
    input  logic [31:0] packet_size,
    input  logic        adc_valid,
    input  logic [11:0] adc_data,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic        overflow,
    output logic        done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t state, state_nx;

    logic [29:0] n_words;
    logic [29:0] pushed;
    logic        tmode;
    logic        phase;
    logic [11:0] tcnt;
    logic [11:0] low_smp;
    logic [11:0] sample;

    logic [32:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [32:0] head;

    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic word_rdy;
    logic push;
    logic pop;
    logic last_word;
    logic unused_size_lsbs;

    assign unused_size_lsbs = ^packet_size[1:0];

    // Full comes from registered pointers only, so a same-cycle pop
    // never makes room for the push that coincides with it.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign sample    = tmode ? tcnt : adc_data;
    assign accept    = start && (packet_size[31:2] != 30'd0);
    assign word_rdy  = (state == CAPTURE) && adc_valid && phase;
    assign push      = word_rdy && !fifo_full;
    assign last_word = (pushed + 30'd1) == n_words;
    assign pop       = m_axis_tvalid && m_axis_tready;

    assign head          = mem[rd_ptr[AW-1:0]];
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? 32'd0 : head[31:0];
    assign m_axis_tlast  = !fifo_empty && head[32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                if (push && last_word) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_axis_tlast) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_words  <= 30'd0;
            pushed   <= 30'd0;
            tmode    <= 1'b0;
            phase    <= 1'b0;
            tcnt     <= 12'd0;
            low_smp  <= 12'd0;
            overflow <= 1'b0;
            done     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            done <= (state == DRAIN) && pop && m_axis_tlast;
            if ((state == IDLE) && accept) begin
                n_words  <= packet_size[31:2];
                tmode    <= test_mode;
                phase    <= 1'b0;
                pushed   <= 30'd0;
                tcnt     <= 12'd0;
                overflow <= 1'b0;
            end else if ((state == CAPTURE) && adc_valid) begin
                phase <= !phase;
                if (tmode) begin
                    tcnt <= tcnt + 12'd1;
                end
                if (!phase) begin
                    low_smp <= sample;
                end else if (fifo_full) begin
                    overflow <= 1'b1;
                end else begin
                    pushed <= pushed + 30'd1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {last_word, 4'b0, sample, 4'b0, low_smp};
        end
    end

endmodule
